// File: rtl/hex_display_scheduler_if.sv
// ---------------------------------------------------------------------------
// hex_display_scheduler_if
// Request/grant and display bundle between two value sources (A, B) and the
// six-digit seven-segment scheduler.
//   req_a/req_b   : requester wants the display, held until its grant
//   data_a/data_b : 24-bit value, nibble k goes to digit k, stable while req
//   gnt_a/gnt_b   : one-cycle grant pulses, data captured on that edge
//   busy          : high from grant until the sweep completes
//   done          : one-cycle pulse after the last digit is written
//   hex[k]        : digit k segments, active-low, bit0=a .. bit6=g
// master = requester/board side, slave = the scheduler.
// ---------------------------------------------------------------------------
interface hex_display_scheduler_if;
  logic             req_a;
  logic [23:0]      data_a;
  logic             req_b;
  logic [23:0]      data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             done;
  logic [5:0][6:0]  hex;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  gnt_a, gnt_b, busy, done, hex
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output gnt_a, gnt_b, busy, done, hex
  );
endinterface

// File: rtl/hex_display_scheduler.sv
// ---------------------------------------------------------------------------
// hex_display_scheduler
// Shares the HEX5..HEX0 bank between two requesters. A round-robin arbiter
// grants one request, captures its 24-bit value, then a sweep FSM writes one
// digit per divider tick through a single shared hex-to-segment decoder.
// Ports:
//   i_clk   : system clock, all state changes on its rising edge
//   i_rst_n : asynchronous active-low reset (blanks display, clears flags)
//   bus     : hex_display_scheduler_if.slave (requests, grants, status, hex)
// Parameters:
//   DIV_COUNT : clock cycles per sweep tick (>= 1)
//   CNT_W     : divider width, 2**CNT_W >= DIV_COUNT
// ---------------------------------------------------------------------------
module hex_display_scheduler #(
  parameter int DIV_COUNT = 50000,
  parameter int CNT_W     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  hex_display_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  logic [23:0]      r_buf;
  logic [CNT_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic             r_last_b;   // 1 when the most recent grant went to B
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_busy;
  logic             r_done;
  logic [5:0][6:0]  r_hex;

  logic             w_tick;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic             w_pick_b;

  assign w_tick = (r_div == CNT_W'(DIV_COUNT - 1));

  // Single decoder: the nibble for the digit currently being written.
  assign w_nib = r_buf[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  // B wins when it is the only requester, or on a tie when A went last.
  assign w_pick_b = bus.req_b && !(bus.req_a && r_last_b);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_buf    <= '0;
      r_div    <= '0;
      r_idx    <= '0;
      r_last_b <= 1'b1;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hex    <= {6{7'h7F}};
    end else begin
      // Grant and done are single-cycle pulses.
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_a || bus.req_b) begin
            r_gnt_a  <= !w_pick_b;
            r_gnt_b  <= w_pick_b;
            r_buf    <= w_pick_b ? bus.data_b : bus.data_a;
            r_last_b <= w_pick_b;
            r_div    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (w_tick) begin
            r_div        <= '0;
            r_hex[r_idx] <= w_seg;
            r_idx        <= r_idx + 3'd1;
            if (r_idx == 3'd5) begin
              r_state <= S_FINISH;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_a = r_gnt_a;
  assign bus.gnt_b = r_gnt_b;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.hex   = r_hex;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scheduler
// Two scheduler instances: u_dut4 (DIV_COUNT=4) for arbitration and timing,
// u_dut1 (DIV_COUNT=1) for the full decode sweep. Expected displays come from
// a per-instance model: last grantee, segment lookup table, and the rule that
// digit k takes its new value DIV_COUNT*(k+1) cycles after the grant edge.
// ---------------------------------------------------------------------------
module tb_hex_display_scheduler;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_display_scheduler_if i4 ();
  hex_display_scheduler_if i1 ();

  hex_display_scheduler #(.DIV_COUNT(4), .CNT_W(16)) u_dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (i4)
  );

  hex_display_scheduler #(.DIV_COUNT(1), .CNT_W(4)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (i1)
  );

  int checks = 0;
  int failures = 0;

  logic [6:0] exp_hex [2][6];
  bit         last_b  [2];

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [41:0] obs_hex(input bit w);
    return w ? i1.hex : i4.hex;
  endfunction

  function automatic logic [1:0] obs_gnt(input bit w);
    return w ? {i1.gnt_a, i1.gnt_b} : {i4.gnt_a, i4.gnt_b};
  endfunction

  function automatic logic obs_busy(input bit w);
    return w ? i1.busy : i4.busy;
  endfunction

  function automatic logic obs_done(input bit w);
    return w ? i1.done : i4.done;
  endfunction

  function automatic logic [41:0] exp_pack(input bit w);
    logic [41:0] p;
    for (int k = 0; k < 6; k++) p[7*k +: 7] = exp_hex[w][k];
    return p;
  endfunction

  function automatic void reset_model();
    for (int w = 0; w < 2; w++) begin
      last_b[w] = 1'b1;
      for (int k = 0; k < 6; k++) exp_hex[w][k] = 7'h7F;
    end
  endfunction

  task automatic set_req(input bit w, input bit is_b, input bit v);
    if (w) begin
      if (is_b) i1.req_b = v; else i1.req_a = v;
    end else begin
      if (is_b) i4.req_b = v; else i4.req_a = v;
    end
  endtask

  task automatic check_quiet(input string tag, input bit w, input int cyc);
    chk({tag, "_gnt"}, cyc, 64'(obs_gnt(w)), 64'(2'b00));
    chk({tag, "_busy"}, cyc, 64'(obs_busy(w)), 64'(1'b0));
    chk({tag, "_done"}, cyc, 64'(obs_done(w)), 64'(1'b0));
    chk({tag, "_hex"}, cyc, 64'(obs_hex(w)), 64'(exp_pack(w)));
  endtask

  // Called at a negedge with requests already set; the next rising edge is
  // the grant edge. Returns on the negedge after the done pulse appears.
  task automatic do_sweep(input bit w, input int raise_b_at, input int drop_b_at, input bit hold);
    int          div;
    int          last;
    bit          ra, rb, pick_b;
    logic [23:0] d;
    div  = w ? 1 : 4;
    last = 6 * div + 1;
    ra   = w ? i1.req_a : i4.req_a;
    rb   = w ? i1.req_b : i4.req_b;
    pick_b = rb && !(ra && last_b[w]);
    d = pick_b ? (w ? i1.data_b : i4.data_b) : (w ? i1.data_a : i4.data_a);
    @(posedge clk);
    @(negedge clk);
    chk("grant", 0, 64'(obs_gnt(w)), 64'({!pick_b, pick_b}));
    chk("busy_at_grant", 0, 64'(obs_busy(w)), 64'(1'b1));
    chk("done_at_grant", 0, 64'(obs_done(w)), 64'(1'b0));
    $display("sweep dut%0d grant=%s data=%06h", w ? 1 : 4, pick_b ? "B" : "A", d);
    last_b[w] = pick_b;
    if (!hold) set_req(w, pick_b, 1'b0);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++)
        if (c >= div * (k + 1)) exp_hex[w][k] = SEG[d[4*k +: 4]];
      chk("hex", c, 64'(obs_hex(w)), 64'(exp_pack(w)));
      chk("gnt_quiet", c, 64'(obs_gnt(w)), 64'(2'b00));
      chk("busy", c, 64'(obs_busy(w)), 64'(c < last));
      chk("done", c, 64'(obs_done(w)), 64'(c == last));
      if (c == raise_b_at) set_req(w, 1'b1, 1'b1);
      if (c == drop_b_at)  set_req(w, 1'b1, 1'b0);
    end
  endtask

  initial begin
    i4.req_a = 0; i4.req_b = 0; i4.data_a = '0; i4.data_b = '0;
    i1.req_a = 0; i1.req_b = 0; i1.data_a = '0; i1.data_b = '0;
    reset_model();

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet("reset4", 1'b0, 0);
    check_quiet("reset1", 1'b1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, known value
    i4.data_a = 24'h0123AF;
    i4.req_a = 1'b1;
    do_sweep(1'b0, -1, -1, 1'b0);
    chk("single_hex0", 0, 64'(i4.hex[0]), 64'(7'h0E));
    chk("single_hex1", 0, 64'(i4.hex[1]), 64'(7'h08));
    chk("single_hex2", 0, 64'(i4.hex[2]), 64'(7'h30));
    chk("single_hex3", 0, 64'(i4.hex[3]), 64'(7'h24));
    chk("single_hex4", 0, 64'(i4.hex[4]), 64'(7'h79));
    chk("single_hex5", 0, 64'(i4.hex[5]), 64'(7'h40));

    // B raised during A's sweep waits for A's done
    i4.data_a = 24'($urandom);
    i4.data_b = 24'($urandom);
    i4.req_a = 1'b1;
    do_sweep(1'b0, 3, -1, 1'b0);
    do_sweep(1'b0, -1, -1, 1'b0);

    // Withdrawal: B pulsed and dropped during A's sweep
    i4.data_a = 24'($urandom);
    i4.data_b = 24'($urandom);
    i4.req_a = 1'b1;
    do_sweep(1'b0, 5, 12, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_quiet("withdraw", 1'b0, c);
    end

    // Reset mid-sweep: blanks immediately, no done afterwards
    i4.data_a = 24'($urandom);
    i4.req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i4.req_a = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check_quiet("async_reset4", 1'b0, 0);
    check_quiet("async_reset1", 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check_quiet("post_reset", 1'b0, c);
    end

    // Tie from reset with both requests held: A, B, A
    i4.data_a = 24'($urandom);
    i4.data_b = 24'($urandom);
    i4.req_a = 1'b1;
    i4.req_b = 1'b1;
    do_sweep(1'b0, -1, -1, 1'b1);
    do_sweep(1'b0, -1, -1, 1'b1);
    do_sweep(1'b0, -1, -1, 1'b1);
    i4.req_a = 1'b0;
    i4.req_b = 1'b0;

    // Full decode sweep at DIV_COUNT=1
    i1.data_a = 24'h456789;
    i1.req_a = 1'b1;
    do_sweep(1'b1, -1, -1, 1'b0);
    chk("dec_hex0", 0, 64'(i1.hex[0]), 64'(7'h10));
    chk("dec_hex1", 0, 64'(i1.hex[1]), 64'(7'h00));
    chk("dec_hex2", 0, 64'(i1.hex[2]), 64'(7'h78));
    chk("dec_hex3", 0, 64'(i1.hex[3]), 64'(7'h02));
    chk("dec_hex4", 0, 64'(i1.hex[4]), 64'(7'h12));
    chk("dec_hex5", 0, 64'(i1.hex[5]), 64'(7'h19));
    i1.data_a = 24'hBCDEF0;
    i1.req_a = 1'b1;
    do_sweep(1'b1, -1, -1, 1'b0);
    chk("dec_hex0", 1, 64'(i1.hex[0]), 64'(7'h40));
    chk("dec_hex1", 1, 64'(i1.hex[1]), 64'(7'h0E));
    chk("dec_hex2", 1, 64'(i1.hex[2]), 64'(7'h06));
    chk("dec_hex3", 1, 64'(i1.hex[3]), 64'(7'h21));
    chk("dec_hex4", 1, 64'(i1.hex[4]), 64'(7'h46));
    chk("dec_hex5", 1, 64'(i1.hex[5]), 64'(7'h03));

    // Random B-only sweep on the fast instance
    i1.data_b = 24'($urandom);
    i1.req_b = 1'b1;
    do_sweep(1'b1, -1, -1, 1'b0);

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_quiet("final_idle4", 1'b0, c);
      check_quiet("final_idle1", 1'b1, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
- Owns the six-digit seven-segment bank HEX5..HEX0 and shares it between two requesters, A and B, each of which wants to show a 24-bit hex value.
- A round-robin arbiter grants one request at a time and captures its value into a display buffer.
- A sweep FSM then pushes the six nibbles through one shared hex-to-segment decode, one digit per divider tick, into registered segment outputs.
- Sits between datapath blocks (counters, ALUs) and the board displays.

Parameters:
- DIV_COUNT, 50000, clock cycles per sweep tick; legal minimum is 1, where a tick occurs every cycle.
- CNT_W, 16, width of the divider counter; must satisfy 2^CNT_W >= DIV_COUNT.

Ports:
- Clock  input  1  system clock (CLOCK_50 domain); all state changes on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A wants the display; held high until gnt_a.
- data_a  input  24  A's value; nibble k shown on HEXk; must be stable while req_a is high.
- req_b  input  1  requester B wants the display.
- data_b  input  24  B's value, same layout as data_a.
- gnt_a  output  1  one-cycle pulse; data_a captured on this edge.
- gnt_b  output  1  one-cycle pulse; data_b captured on this edge.
- busy  output  1  high from grant until the sweep completes.
- done  output  1  one-cycle pulse after the last digit is written.
- HEX0..HEX5  output  7 each  registered segments, active-low; bit0=a .. bit6=g.

Behaviour:
- Reset (async, Resetn=0):
  - state=IDLE.
  - HEX0..HEX5 = 7'h7F (blank).
  - gnt_a = gnt_b = busy = done = 0.
  - buffer = 0, divider = 0, digit index = 0.
  - last_grant = B, so A wins the first tie.
- Reset mid-sweep aborts the sweep immediately. Displays blank and no done pulse is issued.
- FSM states are IDLE, SWEEP and FINISH.
- IDLE:
  - If req_a or req_b is high, grant exactly one requester and go to SWEEP.
  - If only one request is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - On the grant edge: gnt_x=1 for that cycle only, buffer<=data_x, last_grant<=x, divider<=0, index<=0, busy<=1.
- SWEEP:
  - The divider increments every cycle. tick = (divider==DIV_COUNT-1), and the divider wraps to 0 on tick.
  - On tick: HEX[index] <= decode(buffer[4*index+3:4*index]) and index increments.
  - On the tick where index==5, go to FINISH.
  - Digit k updates exactly DIV_COUNT*(k+1) cycles after the grant edge.
- FINISH (one cycle): done=1, busy<=0, then return to IDLE.
  - A new grant is possible at the earliest on the cycle after FINISH.
  - Back-to-back requests are therefore separated by at least 2 cycles of IDLE/FINISH.
- Requests raised during SWEEP or FINISH are not granted. They wait, and must remain asserted.
- Dropping a req before its grant withdraws it; no state is retained for it.
- HEX outputs not yet rewritten in the current sweep hold their previous values.
- gnt_a and gnt_b are never high together and never high outside the IDLE→SWEEP edge.
- Decode map (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- There is a single decode instance, muxed by index. It is not replicated per digit.

Test Plan:
- Reset: assert Resetn=0 mid-operation -> all HEX=7'h7F, gnt/busy/done=0 asynchronously, before the next clock edge.
- Single request: DIV_COUNT=4, req_a=1, data_a=24'h0123AF -> gnt_a pulses 1 cycle. HEX0=7'h0E at +4, HEX1=7'h08 at +8, HEX2=7'h30 at +12, HEX3=7'h24 at +16, HEX4=7'h79 at +20, HEX5=7'h40 at +24. done pulses at +25, busy low after it.
- Tie and fairness:
  - From reset, req_a=req_b=1 held -> first grant to A, second to B, third to A.
  - No overlapping grants.
  - Each sweep completes with done before the next grant.
- Request during sweep: raise req_b 3 cycles after gnt_a -> gnt_b only after A's done.
  - HEX values from A stay intact until B's sweep rewrites them digit by digit.
- Full decode sweep: data 24'h456789 then 24'hBCDEF0 (DIV_COUNT=1) -> every HEX value matches the decode map.
  - Digits rewritten on consecutive cycles.
- Withdrawal: req_b pulsed during A's sweep and dropped before its done -> no gnt_b, FSM returns to IDLE and stays idle.
